key_pulse_conditioner: RTL
==========================

Name: key_pulse_conditioner

Overview:
- Upstream input stage for the locker and other keypad-driven blocks.
- Takes N raw, bouncing, asynchronous push-button inputs (active-low, board pull-ups) and turns them into clean single-cycle events in the clk domain.
- Events: press pulse, release pulse, debounced level, long-press pulse, plus optional auto-repeat.
- Each key is handled independently.

Parameters:
- N, 3, number of keys.
- DEB_CYCLES, 240000, consecutive stable cycles needed to accept a level change (20 ms at 12 MHz); minimum 2.
- LONG_CYCLES, 12000000, debounced-held cycles before key_long fires (1 s at 12 MHz); must exceed DEB_CYCLES.
- REPEAT_CYCLES, 2400000, auto-repeat period after a long press (only used with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- key  input  N  raw buttons, 0 = pressed, asynchronous to clk.
- key_state  output  N  debounced level, 1 = pressed.
- key_pulse  output  N  one-cycle pulse on accepted press (and on each repeat when enabled).
- key_release  output  N  one-cycle pulse on accepted release.
- key_long  output  N  one-cycle pulse when a press has been held LONG_CYCLES.

Behaviour:
- Clock and reset: reset rst_n is synchronous, active-low; clock is clk.
- Reset values:
  - sync flops = all 1 (released).
  - key_state = 0, key_pulse = 0, key_release = 0, key_long = 0.
  - All counters = 0, long_done flags = 0.
- Synchronizer: two-flop synchronizer per key on the raw input. The inverted output is s[i] (1 = pressed).
- Debounce, per key:
  - Counter dc[i], width $clog2(DEB_CYCLES+1).
  - If s[i] == key_state[i]: dc[i] <= 0.
  - Else: dc[i] increments.
  - When dc[i] == DEB_CYCLES-1 and s[i] still differs: key_state[i] toggles and dc[i] <= 0.
  - Any return to the old level before then clears dc[i], so glitches shorter than DEB_CYCLES never propagate.
- Event outputs (registered):
  - key_pulse[i] is high for exactly one cycle, in the cycle after key_state[i] rises.
  - key_release[i] is high for exactly one cycle, in the cycle after key_state[i] falls.
  - Latency from the first clk edge sampling key[i]=0 to key_pulse[i]=1 is DEB_CYCLES+3 edges. The release path has the same latency.
- Hold/long press, per key:
  - Counter hc[i], width $clog2(LONG_CYCLES+1). It counts while key_state[i]=1 and long_done[i]=0.
  - When hc[i] reaches LONG_CYCLES-1: key_long[i] pulses one cycle and long_done[i] <= 1. The counter then stops (saturates; no wrap, no second key_long).
  - key_state[i]=0 clears hc[i] and long_done[i].
  - A release during the key_long cycle still produces key_release on schedule.
- Simultaneous events: keys are fully independent. Any combination of bits may pulse in the same cycle. No priority encoding is performed; the consumer resolves priority.
- Reset mid-operation:
  - All state returns to released.
  - A key still held after rst_n deasserts is treated as a new press: key_pulse follows DEB_CYCLES+3 edges after the first sampling edge with rst_n=1. No key_release is emitted for the press interrupted by reset.
- Outputs never pulse during reset.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - After key_long[i] fires, per-key counter rc[i] (width $clog2(REPEAT_CYCLES+1)) runs while the key stays pressed.
  - Every REPEAT_CYCLES cycles, key_pulse[i] pulses one cycle. The first repeat comes REPEAT_CYCLES cycles after the key_long pulse.
  - Release clears rc[i] immediately; no repeat pulse is issued in or after the release cycle.
- Undefined: rc logic is absent, and key_pulse fires only once per accepted press.

Test Plan:
Use N=3, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
- Reset: hold rst_n=0 for 3 cycles with key=3'b111 -> all outputs 0; key_state=000 after release of reset.
- Clean press: key[0] low at edge 0 and held -> key_pulse=001 during the cycle after edge 7 only; key_state[0]=1 from edge 7. Key high again at edge 30 -> key_release=001 one cycle after edge 37.
- Bounce rejection: key[1] low for 3 cycles, high 1, low 2, high -> no pulses on any output; key_state=000 throughout.
- Long press: key[2] held for 40 cycles -> one key_pulse[2], then key_long[2] exactly once, 20 cycles after key_state[2] rises; no further key_long while held.
- Simultaneous + reset: key[0] and key[1] low at the same edge -> key_pulse=011 in one cycle. Then rst_n=0 for 2 cycles while both keys are still held -> outputs 0, no key_release. After reset the keys are re-accepted -> key_pulse=011 again DEB_CYCLES+3 edges later.
- KEY_AUTO_REPEAT_EN defined: hold key[0] for 50 cycles -> key_pulse[0] at press, key_long[0], then key_pulse[0] repeats every 8 cycles. Repeats stop at release. With the macro undefined -> single key_pulse only.

Source files
------------

// File: rtl/key_pulse_conditioner_if.sv
// Keypad bundle: raw active-low buttons in, conditioned per-key events out.
interface key_pulse_conditioner_if #(
   parameter int unsigned N = 3
) ();
   logic [N-1:0] key;
   logic [N-1:0] key_state;
   logic [N-1:0] key_pulse;
   logic [N-1:0] key_release;
   logic [N-1:0] key_long;

   modport master (
      output key,
      input  key_state, key_pulse, key_release, key_long
   );

   modport slave (
      input  key,
      output key_state, key_pulse, key_release, key_long
   );
endinterface

// File: rtl/key_pulse_conditioner.sv
// Per-key synchronise, debounce and press/release/long-press event generation.
// Optional auto-repeat of key_pulse after a long press: define KEY_AUTO_REPEAT_EN.
module key_pulse_conditioner #(
   parameter int unsigned N             = 3,
   parameter int unsigned DEB_CYCLES    = 240000,
   parameter int unsigned LONG_CYCLES   = 12000000,
   parameter int unsigned REPEAT_CYCLES = 2400000
) (
   input logic                    clk,
   input logic                    rst_n,
   key_pulse_conditioner_if.slave kp
);
   localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

   if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES || REPEAT_CYCLES < 1) begin : g_param_chk
      $error("key_pulse_conditioner: illegal cycle parameters");
   end

   logic [N-1:0] sync1_q, sync2_q, s_q;
   logic [N-1:0] lvl_q, lvl_d;
   logic [N-1:0] state_q;
   logic [N-1:0] pulse_q, pulse_d;
   logic [N-1:0] rel_q, rel_d;
   logic [N-1:0] long_q, long_d;
   logic [N-1:0] ldone_q, ldone_d;
   logic [N-1:0] rep;
   logic [DW-1:0] dc_q [N];
   logic [DW-1:0] dc_d [N];
   logic [HW-1:0] hc_q [N];
   logic [HW-1:0] hc_d [N];

   always_comb begin
      lvl_d   = lvl_q;
      ldone_d = ldone_q;
      long_d  = '0;
      for (int i = 0; i < N; i++) begin
         dc_d[i] = dc_q[i];
         hc_d[i] = hc_q[i];
         if (s_q[i] == lvl_q[i]) begin
            dc_d[i] = '0;
         end else if (dc_q[i] == DW'(DEB_CYCLES - 1)) begin
            dc_d[i]  = '0;
            lvl_d[i] = ~lvl_q[i];
         end else begin
            dc_d[i] = dc_q[i] + DW'(1);
         end
         // Hold counter saturates once key_long has fired for this press.
         if (!state_q[i]) begin
            hc_d[i]    = '0;
            ldone_d[i] = 1'b0;
         end else if (!ldone_q[i]) begin
            if (hc_q[i] == HW'(LONG_CYCLES - 1)) begin
               long_d[i]  = 1'b1;
               ldone_d[i] = 1'b1;
            end else begin
               hc_d[i] = hc_q[i] + HW'(1);
            end
         end
      end
      pulse_d = (lvl_q & ~state_q) | rep;
      rel_d   = ~lvl_q & state_q;
   end

`ifdef KEY_AUTO_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
   logic [RW-1:0] rc_q [N];
   logic [RW-1:0] rc_d [N];

   // Gated on the pre-output level so no repeat can land in the release cycle.
   always_comb begin
      rep = '0;
      for (int i = 0; i < N; i++) begin
         rc_d[i] = rc_q[i];
         if (!(lvl_q[i] && ldone_q[i])) begin
            rc_d[i] = '0;
         end else if (rc_q[i] == RW'(REPEAT_CYCLES - 1)) begin
            rc_d[i] = '0;
            rep[i]  = 1'b1;
         end else begin
            rc_d[i] = rc_q[i] + RW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!rst_n) rc_q[i] <= '0;
         else        rc_q[i] <= rc_d[i];
      end
   end
`else
   assign rep = '0;
`endif

   // s_q registers the inverted synchroniser output (1 = pressed).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         s_q     <= '0;
         lvl_q   <= '0;
         state_q <= '0;
         pulse_q <= '0;
         rel_q   <= '0;
         long_q  <= '0;
         ldone_q <= '0;
         for (int i = 0; i < N; i++) begin
            dc_q[i] <= '0;
            hc_q[i] <= '0;
         end
      end else begin
         sync1_q <= kp.key;
         sync2_q <= sync1_q;
         s_q     <= ~sync2_q;
         lvl_q   <= lvl_d;
         state_q <= lvl_q;
         pulse_q <= pulse_d;
         rel_q   <= rel_d;
         long_q  <= long_d;
         ldone_q <= ldone_d;
         for (int i = 0; i < N; i++) begin
            dc_q[i] <= dc_d[i];
            hc_q[i] <= hc_d[i];
         end
      end
   end

   assign kp.key_state   = state_q;
   assign kp.key_pulse   = pulse_q;
   assign kp.key_release = rel_q;
   assign kp.key_long    = long_q;
endmodule
